global_mem_arbiter: RTL and testbench
=====================================

# global_mem_arbiter

Arbitrates the global-memory requests of `NUM_CORES` gpuCore instances onto one single-beat external memory port. It sits directly downstream of the cores. It consumes each core's `readingMemoryDataGlobal` / `writingMemoryDataGlobal` strobes together with `marOut` / `mdrOut`. It returns `finishedReadMemoryDataGlobal`, `finishedWriteMemoryDataGlobal` and `MDRIn`. Grants are round-robin, and exactly one transaction is outstanding at a time.

## Interface
- `NUM_CORES`, 4: number of attached cores; must be at least 2.
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `resetN`  in  1  reset, asynchronous and active-low.
- `coreRead`  in  NUM_CORES  per-core `readingMemoryDataGlobal`.
- `coreWrite`  in  NUM_CORES  per-core `writingMemoryDataGlobal`.
- `coreMar`  in  NUM_CORES×ADDR_W  per-core `marOut`.
- `coreMdr`  in  NUM_CORES×DATA_W  per-core `mdrOut`.
- `coreFinishedRead`  out  NUM_CORES  one-hot read-completion pulse.
- `coreFinishedWrite`  out  NUM_CORES  one-hot write-completion pulse.
- `coreMdrIn`  out  DATA_W  read data, broadcast to every core's `MDRIn`.
- `memReq`  out  1  external request, held until acknowledged.
- `memWe`  out  1  1 = write, 0 = read; valid while `memReq` is high.
- `memAddr`  out  ADDR_W  transaction address.
- `memWdata`  out  DATA_W  write data.
- `memAck`  in  1  one-cycle completion from memory.
- `memRdata`  in  DATA_W  read data; valid in the `memAck` cycle.
- `busy`  out  1  high whenever the FSM is not in Idle.

## Operation
- The FSM has three states: Idle, Issue and Respond.
- **Idle**
  - Request vector `req[i] = coreRead[i] | coreWrite[i]`.
  - If any bit of `req` is set, the grant goes to the first requester after `lastGrant`, searching in increasing index order and wrapping from `NUM_CORES-1` to 0.
  - On grant, latch the grant index, `coreMar`, `coreMdr` and the write flag (`coreWrite[g]`). Then go to Issue.
- **Issue**
  - Drive `memReq=1`, `memWe`, `memAddr` and `memWdata` from the latches; these stay stable until `memAck`.
  - On `memAck`, capture `memRdata` into the read-data register, set `lastGrant` to the granted index, and go to Respond.
- **Respond**
  - For one cycle, assert `coreFinishedRead[g]` or `coreFinishedWrite[g]` (only for the granted core).
  - Return to Idle the following cycle.
- `coreMdrIn` always drives the read-data register. It holds its value until the next read's `memAck`; writes do not alter it.
- Core inputs are sampled only in Idle. The granted core drops its strobe on the edge that ends Respond, so a completed core is never re-granted off a stale strobe.
- Protocol violation: if a core raises both `coreRead[i]` and `coreWrite[i]`, the write is serviced and a simulation assertion fires.
- Requests from non-granted cores remain pending; cores hold their strobes until they are served.
- Arbitration is fair: with every core requesting, each core is served exactly once in every `NUM_CORES` consecutive grants.

## Timing
- Reset values: all outputs are 0, the FSM is in Idle, `lastGrant = NUM_CORES-1` (so core 0 wins first), and the read-data register is 0.
- Reset asserted mid-transaction: `memReq` drops immediately and asynchronously, and no finished pulse is produced. The external memory must tolerate an abandoned request.
- Latency, with the request first seen in Idle at cycle 0:
  - `memReq` is high from cycle 1.
  - `memAck` arrives at cycle k ≥ 1.
  - The finished pulse and valid `coreMdrIn` are present in cycle k+1.
  - Idle is reached at cycle k+2.
  - Minimum request-to-finish latency is 2 cycles. Back-to-back throughput is one transaction per 3 cycles at zero wait states.
- Any `memAck` seen outside Issue is ignored and flagged by an assertion.
- All outputs are registered, or decoded purely from state and registers; there are no combinational paths from core inputs to memory outputs.

## Structure
- Shared package `gpu_pkg` holds:
  - `arbState_t` enum {Idle, Issue, Respond};
  - the default `NUM_CORES`, `ADDR_W` and `DATA_W` constants.
- Sub-module `rrPicker`: purely combinational. Inputs are `req[NUM_CORES]` and `lastGrant`; outputs are `grantIdx` and `grantValid`. Instantiated once.
- The top level holds the FSM, the latches and the `lastGrant` register.

## Test plan
- **Single read:** core 2 reads 0x100, memory acks 3 cycles after `memReq` with 0xDEADBEEF → `memAddr`=0x100 and `memWe`=0; `coreFinishedRead`=4'b0100 for exactly one cycle, with `coreMdrIn`=0xDEADBEEF in that same cycle.
- **Single write:** core 0 writes 0x55 to 0x20, zero-wait ack → `memWe`=1, `memWdata`=0x55; `coreFinishedWrite`=4'b0001 two cycles after the request; `coreMdrIn` is unchanged.
- **Round-robin fairness:** all 4 cores request continuously and re-request immediately after each finish → grant order 0,1,2,3,0,1,…, with no core served twice in any window of 4 grants.
- **Wrap and skip:** after a grant to core 3, cores 1 and 2 request → core 1 is served first, then core 2.
- **Reset mid-Issue:** drive `resetN` low while `memReq`=1 → `memReq`, `busy` and all finished outputs go to 0 asynchronously; after release the next grant goes to core 0.
- **Stray ack:** `memAck` pulsed while in Idle → no state change, no finished pulse, and the assertion fires.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared types and default sizing for the gpuCore global-memory path.
package gpu_pkg;
    localparam int DEF_NUM_CORES = 4;
    localparam int DEF_ADDR_W    = 32;
    localparam int DEF_DATA_W    = 32;

    typedef enum logic [1:0] {
        Idle    = 2'd0,
        Issue   = 2'd1,
        Respond = 2'd2
    } arbState_t;
endpackage

// File: rtl/global_mem_arbiter_rr_picker.sv
// Combinational round-robin picker: first requester strictly after lastGrant, wrapping.
module rrPicker
    import gpu_pkg::*;
#(
    parameter int NUM_CORES = DEF_NUM_CORES,
    localparam int IDX_W    = $clog2(NUM_CORES)
) (
    input  logic [NUM_CORES-1:0] req,
    input  logic [IDX_W-1:0]     lastGrant,
    output logic [IDX_W-1:0]     grantIdx,
    output logic                 grantValid
);
    logic             w_hi_valid;
    logic [IDX_W-1:0] w_hi_idx;
    logic             w_lo_valid;
    logic [IDX_W-1:0] w_lo_idx;

    // Descending scan so the lowest index in each half overwrites the others.
    always_comb begin
        w_hi_valid = 1'b0;
        w_hi_idx   = '0;
        w_lo_valid = 1'b0;
        w_lo_idx   = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (req[i]) begin
                if (IDX_W'(i) > lastGrant) begin
                    w_hi_valid = 1'b1;
                    w_hi_idx   = IDX_W'(i);
                end else begin
                    w_lo_valid = 1'b1;
                    w_lo_idx   = IDX_W'(i);
                end
            end
        end
        grantValid = w_hi_valid | w_lo_valid;
        grantIdx   = w_hi_valid ? w_hi_idx : w_lo_idx;
    end
endmodule

// File: rtl/global_mem_arbiter.sv
// Round-robin arbiter of per-core global-memory strobes onto one single-beat memory port,
// one transaction outstanding at a time.
module global_mem_arbiter
    import gpu_pkg::*;
#(
    parameter int NUM_CORES = DEF_NUM_CORES,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W
) (
    input  logic                              clk,
    input  logic                              resetN,
    input  logic [NUM_CORES-1:0]              coreRead,
    input  logic [NUM_CORES-1:0]              coreWrite,
    input  logic [NUM_CORES-1:0][ADDR_W-1:0]  coreMar,
    input  logic [NUM_CORES-1:0][DATA_W-1:0]  coreMdr,
    output logic [NUM_CORES-1:0]              coreFinishedRead,
    output logic [NUM_CORES-1:0]              coreFinishedWrite,
    output logic [DATA_W-1:0]                 coreMdrIn,
    output logic                              memReq,
    output logic                              memWe,
    output logic [ADDR_W-1:0]                 memAddr,
    output logic [DATA_W-1:0]                 memWdata,
    input  logic                              memAck,
    input  logic [DATA_W-1:0]                 memRdata,
    output logic                              busy,
    output arbState_t                         dbgState
);
    localparam int IDX_W = $clog2(NUM_CORES);

    arbState_t              r_state;
    arbState_t              w_next_state;
    logic [IDX_W-1:0]       r_grant;
    logic [IDX_W-1:0]       r_last_grant;
    logic                   r_we;
    logic [ADDR_W-1:0]      r_addr;
    logic [DATA_W-1:0]      r_wdata;
    logic [DATA_W-1:0]      r_rdata;
    logic [NUM_CORES-1:0]   w_req;
    logic [IDX_W-1:0]       w_pick_idx;
    logic                   w_pick_valid;
    logic [NUM_CORES-1:0]   w_grant_onehot;

    assign w_req = coreRead | coreWrite;

    rrPicker #(.NUM_CORES(NUM_CORES)) u_picker (
        .req        (w_req),
        .lastGrant  (r_last_grant),
        .grantIdx   (w_pick_idx),
        .grantValid (w_pick_valid)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state <= Idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            Idle:    if (w_pick_valid) w_next_state = Issue;
            Issue:   if (memAck)       w_next_state = Respond;
            Respond: w_next_state = Idle;
            default: w_next_state = Idle;
        endcase
    end

    // A simultaneous read+write strobe latches as a write.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_grant      <= '0;
            r_last_grant <= IDX_W'(NUM_CORES - 1);
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
        end else begin
            if (r_state == Idle && w_pick_valid) begin
                r_grant <= w_pick_idx;
                r_addr  <= coreMar[w_pick_idx];
                r_wdata <= coreMdr[w_pick_idx];
                r_we    <= coreWrite[w_pick_idx];
            end
            if (r_state == Issue && memAck) begin
                r_last_grant <= r_grant;
                if (!r_we) begin
                    r_rdata <= memRdata;
                end
            end
        end
    end

    assign w_grant_onehot    = NUM_CORES'(1) << r_grant;
    assign memReq            = (r_state == Issue);
    assign memWe             = memReq & r_we;
    assign memAddr           = r_addr;
    assign memWdata          = r_wdata;
    assign coreMdrIn         = r_rdata;
    assign busy              = (r_state != Idle);
    assign dbgState          = r_state;
    assign coreFinishedRead  = (r_state == Respond && !r_we) ? w_grant_onehot : '0;
    assign coreFinishedWrite = (r_state == Respond &&  r_we) ? w_grant_onehot : '0;

    a_stray_ack: assert property (@(posedge clk) disable iff (!resetN)
        memAck |-> (r_state == Issue))
        else $warning("stray memAck ignored outside Issue");

    a_read_and_write: assert property (@(posedge clk) disable iff (!resetN)
        (r_state == Idle) |-> ((coreRead & coreWrite) == '0))
        else $warning("core raised read and write together; write serviced");
endmodule

// File: tb/tb_global_mem_arbiter.sv
// Bench for global_mem_arbiter: random and directed core traffic, memory responder,
// transaction-level arbitration model feeding an expected-completion queue.
module tb_global_mem_arbiter;
    import gpu_pkg::*;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic                clk;
    logic                resetN;
    logic [N-1:0]        coreRead, coreWrite;
    logic [N-1:0][AW-1:0] coreMar;
    logic [N-1:0][DW-1:0] coreMdr;
    logic [N-1:0]        coreFinishedRead, coreFinishedWrite;
    logic [DW-1:0]       coreMdrIn;
    logic                memReq, memWe;
    logic [AW-1:0]       memAddr;
    logic [DW-1:0]       memWdata;
    logic                memAck;
    logic [DW-1:0]       memRdata;
    logic                busy;
    arbState_t           dbg_state;

    global_mem_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .resetN(resetN),
        .coreRead(coreRead), .coreWrite(coreWrite), .coreMar(coreMar), .coreMdr(coreMdr),
        .coreFinishedRead(coreFinishedRead), .coreFinishedWrite(coreFinishedWrite),
        .coreMdrIn(coreMdrIn), .memReq(memReq), .memWe(memWe), .memAddr(memAddr),
        .memWdata(memWdata), .memAck(memAck), .memRdata(memRdata), .busy(busy),
        .dbgState(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // core request table, driven onto the strobes
    logic [N-1:0]  pend;
    logic [N-1:0]  op_we;
    logic [AW-1:0] op_addr [N];
    logic [DW-1:0] op_data [N];
    assign coreRead  = pend & ~op_we;
    assign coreWrite = pend & op_we;
    always_comb begin
        for (int i = 0; i < N; i++) begin
            coreMar[i] = op_addr[i];
            coreMdr[i] = op_data[i];
        end
    end

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int raise_cyc [N];
    int fin_cyc [N];
    int glog[$];
    logic [2+1+DW-1:0] exp_q[$];
    logic [DW-1:0] mem_arr [logic [AW-1:0]];
    bit rand_on = 0;
    int pct = 0;
    int fixed_wait = -1;
    bit stray_req = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic logic [DW-1:0] mem_rd(logic [AW-1:0] a);
        if (mem_arr.exists(a)) return mem_arr[a];
        return a ^ 32'h5A5A_0F0F;
    endfunction

    function automatic int rr_pick(logic [N-1:0] v, int last);
        int p;
        for (int k = 1; k <= N; k++) begin
            p = (last + k) % N;
            if (v[p[1:0]]) return p;
        end
        return -1;
    endfunction

    // driver tasks
    task automatic raise(input int c, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        op_we[c]   = we;
        op_addr[c] = a;
        op_data[c] = d;
        pend[c]    = 1'b1;
        raise_cyc[c] = cyc;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (pend == '0 && !busy) break;
        end
        chk("drain", {busy, pend}, 0);
    endtask

    // random core traffic
    initial begin
        forever begin
            @(negedge clk);
            if (rand_on && resetN) begin
                for (int i = 0; i < N; i++) begin
                    if (!pend[i] && $urandom_range(0, 99) < pct) begin
                        raise(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15) * 4), $urandom);
                    end
                end
            end
        end
    end

    // memory responder
    initial begin
        bit started, acked;
        int cnt, w;
        started = 0; acked = 0; cnt = 0; w = 0;
        forever begin
            @(negedge clk);
            memAck = 1'b0;
            if (!resetN) begin
                started = 0; acked = 0;
            end else if (stray_req) begin
                memAck = 1'b1;
                memRdata = $urandom;
                stray_req = 0;
            end else if (memReq && !acked) begin
                if (!started) begin
                    started = 1; cnt = 0;
                    w = (fixed_wait >= 0) ? fixed_wait : $urandom_range(0, 3);
                end
                if (cnt == w) begin
                    memAck = 1'b1;
                    if (memWe) mem_arr[memAddr] = memWdata;
                    else memRdata = mem_rd(memAddr);
                    acked = 1;
                end else begin
                    cnt++;
                end
            end else if (!memReq) begin
                started = 0; acked = 0;
            end
        end
    end

    // monitor / scoreboard
    initial begin
        int last_m, g, gi;
        bit in_txn, resp;
        logic [DW-1:0] last_rd, ed;
        logic [AW-1:0] cur_addr;
        logic cur_we;
        logic [N-1:0] pv, oh;
        logic [2+1+DW-1:0] e;
        last_m = N - 1; in_txn = 0; resp = 0; last_rd = '0; cur_addr = '0; cur_we = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (!resetN) begin
                last_m = N - 1; in_txn = 0; resp = 0; last_rd = '0;
                exp_q.delete();
                continue;
            end
            if (resp) begin
                chk("respond_end_req", memReq, 0);
                chk("respond_end_busy", busy, 0);
                chk("respond_end_fin", {coreFinishedRead, coreFinishedWrite}, 0);
                resp = 0;
            end else if (in_txn) begin
                if (memAck) begin
                    chk("ack_req_drop", memReq, 0);
                    chk("ack_busy", busy, 1);
                    chk("exp_q_nonempty", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e  = exp_q.pop_front();
                        gi = int'(e[DW+2:DW+1]);
                        oh = N'(1) << gi;
                        chk("fin_read",  coreFinishedRead,  e[DW] ? '0 : oh);
                        chk("fin_write", coreFinishedWrite, e[DW] ? oh : '0);
                        chk("mdr_in", coreMdrIn, e[DW-1:0]);
                        pend[gi] = 1'b0;
                        fin_cyc[gi] = cyc;
                    end
                    in_txn = 0;
                    resp = 1;
                end else begin
                    chk("issue_req_held", memReq, 1);
                    chk("issue_addr_stable", memAddr, cur_addr);
                    chk("issue_we_stable", memWe, cur_we);
                    chk("issue_no_fin", {coreFinishedRead, coreFinishedWrite}, 0);
                end
            end else begin
                pv = coreRead | coreWrite;
                chk("idle_mdr_hold", coreMdrIn, last_rd);
                chk("idle_no_fin", {coreFinishedRead, coreFinishedWrite}, 0);
                if (pv != '0) begin
                    g = rr_pick(pv, last_m);
                    chk("grant_req", memReq, 1);
                    chk("grant_busy", busy, 1);
                    chk("grant_addr", memAddr, op_addr[g]);
                    chk("grant_we", memWe, op_we[g]);
                    if (op_we[g]) begin
                        chk("grant_wdata", memWdata, op_data[g]);
                        ed = last_rd;
                    end else begin
                        ed = mem_rd(op_addr[g]);
                        last_rd = ed;
                    end
                    exp_q.push_back({2'(g), op_we[g], ed});
                    glog.push_back(g);
                    cur_addr = op_addr[g];
                    cur_we = op_we[g];
                    last_m = g;
                    in_txn = 1;
                end else begin
                    chk("idle_req", memReq, 0);
                    chk("idle_busy", busy, 0);
                end
            end
        end
    end

    // directed and random sequence
    initial begin
        pend = '0; op_we = '0;
        for (int i = 0; i < N; i++) begin
            op_addr[i] = '0; op_data[i] = '0; raise_cyc[i] = 0; fin_cyc[i] = 0;
        end
        memAck = 1'b0; memRdata = '0;
        resetN = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_memReq", memReq, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fin", {coreFinishedRead, coreFinishedWrite}, 0);
        chk("rst_mdr", coreMdrIn, 0);
        chk("rst_outs", {memWe, memAddr, memWdata}, 0);
        chk("rst_state", dbg_state, Idle);
        resetN = 1'b1;

        // single read, 3 wait cycles
        mem_arr[32'h100] = 32'hDEAD_BEEF;
        fixed_wait = 3;
        @(negedge clk);
        raise(2, 1'b0, 32'h100, 32'h0);
        drain(50);
        chk("read_latency", fin_cyc[2] - raise_cyc[2], 5);
        chk("read_mdr", coreMdrIn, 32'hDEAD_BEEF);

        // single write, zero wait
        fixed_wait = 0;
        @(negedge clk);
        raise(0, 1'b1, 32'h20, 32'h55);
        drain(50);
        chk("write_latency", fin_cyc[0] - raise_cyc[0], 2);
        chk("write_mdr_unchanged", coreMdrIn, 32'hDEAD_BEEF);
        chk("write_mem", mem_rd(32'h20), 32'h55);

        // fairness with all cores requesting continuously
        fixed_wait = -1;
        glog.delete();
        rand_on = 1; pct = 100;
        for (int i = 0; i < 2000 && glog.size() < 40; i++) @(negedge clk);
        rand_on = 0;
        chk("fair_count", glog.size() >= 40, 1);
        if (glog.size() >= 40) begin
            for (int j = 0; j + 3 < 40; j++) begin
                logic [N-1:0] m;
                m = '0;
                for (int k = 0; k < 4; k++) m[glog[j+k]] = 1'b1;
                chk("fair_window", m, 4'hF);
            end
        end
        drain(200);

        // wrap and skip
        @(negedge clk);
        raise(3, 1'b0, 32'h40, 32'h0);
        drain(50);
        glog.delete();
        @(negedge clk);
        raise(1, 1'b1, 32'h44, 32'h11);
        raise(2, 1'b0, 32'h44, 32'h0);
        drain(50);
        chk("wrap_count", glog.size(), 2);
        if (glog.size() >= 2) begin
            chk("wrap_first", glog[0], 1);
            chk("wrap_second", glog[1], 2);
        end
        chk("wrap_read_after_write", coreMdrIn, 32'h11);

        // random mixed traffic
        rand_on = 1; pct = 30;
        repeat (600) @(negedge clk);
        rand_on = 0;
        drain(200);

        // stray ack in Idle
        stray_req = 1;
        repeat (4) @(negedge clk);
        chk("stray_busy", busy, 0);
        chk("stray_state", dbg_state, Idle);

        // reset in the middle of Issue
        fixed_wait = 6;
        @(negedge clk);
        raise(2, 1'b0, 32'h80, 32'h0);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (memReq) break;
        end
        chk("pre_reset_req", memReq, 1);
        #2;
        resetN = 1'b0;
        #1;
        chk("async_rst_req", memReq, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_fin", {coreFinishedRead, coreFinishedWrite}, 0);
        chk("async_rst_mdr", coreMdrIn, 0);
        @(negedge clk);
        raise(0, 1'b0, 32'h84, 32'h0);
        fixed_wait = 0;
        glog.delete();
        repeat (2) @(negedge clk);
        resetN = 1'b1;
        drain(50);
        chk("post_rst_count", glog.size(), 2);
        if (glog.size() >= 2) begin
            chk("post_rst_first", glog[0], 0);
            chk("post_rst_second", glog[1], 2);
        end

        repeat (3) @(negedge clk);
        chk("final_exp_q_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
